sq_encoder: RTL and testbench
=============================

Name: sq_encoder

Overview:
- Canonical-Huffman bitstream encoder: the transmit-side counterpart of the SQ sequence decoder in the sprite decompressor.
- Pops 4-bit symbols from a first-word-fall-through (FWFT) FIFO and looks each up in the canonical symbol table (CCL_code_sq) plus the per-length count vector (CCL_count_sq).
- Emits each codeword MSB-first, one bit per valid/ready transfer, to the bitstream packer.
- Produces exactly the stream SQ consumes for the same table.

Parameters:
- SYM_W, 4, symbol width in bits.
- MAX_LEN, 4, maximum code length in bits (one count nibble per length).
- TAB_N, 16, number of symbol-table entries.
- CNT_W, 16, width of the symbol-total counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; latches table, counts and sym_total; ignored when not IDLE.
- sym_total  in  CNT_W  number of symbols to encode in this job.
- CCL_code_sq  in  TAB_N*SYM_W  symbol table in canonical order; nibble k = entry k (nibble 0 = LSBs).
- CCL_count_sq  in  MAX_LEN*4  nibble i = number of codes of length i+1.
- rdata  in  SYM_W  FIFO head; valid while !rempty.
- rempty  in  1  FIFO empty.
- rinc  out  1  pop strobe.
- bit  out  1  current code bit.
- bit_valid  out  1  bit is valid.
- bit_ready  in  1  sink accepts; a transfer occurs when bit_valid & bit_ready.
- busy  out  1  high from the cycle after start until fin.
- fin  out  1  one-cycle pulse when the job completes.
- err  out  1  sticky per job: symbol not found or bad config; cleared on start.

Behaviour:
- Reset values: rinc, bit, bit_valid, busy, fin, err all 0; FSM in IDLE; all counters 0.
- Reset mid-job aborts immediately. No fin. A partially sent code is dropped.
- On start in IDLE, register the table and counts.
- Compute N = sum of counts, using 5-bit arithmetic.
- Compute canonical first codes:
  - fc[1] = 0.
  - fc[L+1] = (fc[L] + cnt[L]) << 1.
  - fi[L] = index of the first entry of length L = cnt[1] + ... + cnt[L-1].
- Inputs changed mid-job have no effect.
- States:
  - IDLE: start -> CFG.
  - CFG (1 cycle):
    - If N > TAB_N, set err and go to DONE.
    - Else if sym_total == 0, go to DONE.
    - Else go to FETCH.
  - FETCH:
    - Wait while rempty.
    - When !rempty, assert rinc for 1 cycle, register rdata and go to LOOKUP.
  - LOOKUP (1 cycle):
    - Find the lowest index k < N with table[k] == symbol.
    - If found: L = length whose range contains k; code = fc[L] + (k - fi[L]); go to SHIFT.
    - If not found: set err, count the symbol as consumed, skip SHIFT and go to NEXT.
  - SHIFT:
    - bit_valid = 1, bit = code[L-1-j] for j = 0..L-1.
    - j advances only on a transfer.
    - After the last transfer go to NEXT in the same edge.
    - bit and bit_valid must stay stable while bit_ready is low.
  - NEXT:
    - Increment the symbol counter.
    - If it equals sym_total go to DONE, else go to FETCH.
  - DONE: fin = 1 for one cycle, busy drops, go to IDLE.
- Latency: rinc to first bit_valid = 2 cycles.
- Throughput: one symbol per L+2 cycles when bit_ready is held high.
- Duplicate table entries: the lowest index wins.
- cnt[i] == 0: length i is skipped; fc is still propagated.
- Codeword arithmetic is MAX_LEN bits wide; overflow wraps. The table is assumed Kraft-valid apart from the N check.
- A start pulse while busy is ignored.
- rinc is never asserted when rempty is high.

Decomposition:
- Package sq_pkg: SYM_W, MAX_LEN, TAB_N, the FSM state enum (IDLE, CFG, FETCH, LOOKUP, SHIFT, NEXT, DONE) and a code/length struct. Shared with SQ.
- Sub-module sq_code_lookup (combinational): inputs symbol, table, counts, N; outputs found, code, len.
- The FSM, counters and shifter stay in sq_encoder.

Test Plan:
- Config: counts {len1=0, len2=1, len3=5, len4=2}, table entries 0..7 = 5, f, 0, 1, 2, 4, 9, f, sym_total=3. FIFO supplies 5, 0, 9 with bit_ready=1. Required stream is 00 011 1110 (9 bits); fin pulses once; err=0.
- Same config, FIFO supplies f: the lowest index wins, so the output is 010, not 1111.
- FIFO supplies 3 then 4: err=1, no bits emitted for 3. 4 is emitted as 110; fin after 2 symbols.
- bit_ready toggles 2 cycles on / 2 cycles off, with rempty also toggling: the bitstream is identical to the first scenario; bit is held while not ready; no rinc while empty.
- sym_total=0: fin pulses 2 cycles after start, no rinc, no bit_valid. Counts summing to 17: err=1 and fin with no bits.
- rst asserted mid-SHIFT of 1110: all outputs are 0 the next cycle, no fin. A new start then encodes correctly from the first bit.

Source files
------------

// File: rtl/sq_pkg.sv
// Shared types and sizing for the SQ canonical-Huffman encoder/decoder pair.
package sq_pkg;

  localparam int unsigned SYM_W   = 4;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned TAB_N   = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned N_W     = 5;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W   = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    FETCH,
    LOOKUP,
    SHIFT,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] code;
  } code_len_t;

  // Total number of codes; deliberately 5-bit so oversized count sets wrap
  function automatic logic [N_W-1:0] count_sum(input logic [MAX_LEN*NIB_W-1:0] counts);
    logic [N_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      s = s + N_W'(counts[i*NIB_W +: NIB_W]);
    end
    return s;
  endfunction

endpackage

// File: rtl/sq_encoder_if.sv
// FIFO read port and bit-sink handshake of the SQ encoder.
interface sq_encoder_if;
  import sq_pkg::*;

  logic [SYM_W-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             code_bit;
  logic             bit_valid;
  logic             bit_ready;

  modport master (
    input  rdata, rempty, bit_ready,
    output rinc, code_bit, bit_valid
  );

  modport slave (
    output rdata, rempty, bit_ready,
    input  rinc, code_bit, bit_valid
  );

endinterface

// File: rtl/sq_code_lookup.sv
// Combinational canonical-code lookup: symbol -> (code, length) via table index.
module sq_code_lookup
  import sq_pkg::*;
(
  input  logic [SYM_W-1:0]         symbol,
  input  logic [TAB_N*SYM_W-1:0]   sym_table,
  input  logic [MAX_LEN*NIB_W-1:0] counts,
  input  logic [N_W-1:0]           n_codes,
  output logic                     found,
  output code_len_t                cl
);

  always_comb begin : p_lookup
    logic               hit;
    logic [N_W-1:0]     idx;
    logic [MAX_LEN-1:0] fc;
    logic [N_W-1:0]     fi;
    logic [N_W-1:0]     cnt;

    hit   = 1'b0;
    idx   = '0;
    fc    = '0;
    fi    = '0;
    cnt   = '0;
    found = 1'b0;
    cl    = '0;

    // Scan downward so the lowest matching index is the one that sticks
    for (int k = int'(TAB_N) - 1; k >= 0; k--) begin
      if ((N_W'(k) < n_codes) && (sym_table[k*SYM_W +: SYM_W] == symbol)) begin
        hit = 1'b1;
        idx = N_W'(k);
      end
    end

    // Walk lengths, propagating first code and first index even through empty lengths
    for (int l = 0; l < int'(MAX_LEN); l++) begin
      cnt = N_W'(counts[l*NIB_W +: NIB_W]);
      if (hit && !found && (idx >= fi) && (idx < fi + cnt)) begin
        found   = 1'b1;
        cl.len  = LEN_W'(l + 1);
        cl.code = fc + MAX_LEN'(idx - fi);
      end
      fc = MAX_LEN'((fc + MAX_LEN'(cnt)) << 1);
      fi = fi + cnt;
    end
  end

endmodule

// File: rtl/sq_encoder.sv
// SQ canonical-Huffman encoder: FIFO symbols in, MSB-first code bits out.
module sq_encoder
  import sq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         sym_total,
  input  logic [TAB_N*SYM_W-1:0]   CCL_code_sq,
  input  logic [MAX_LEN*NIB_W-1:0] CCL_count_sq,
  sq_encoder_if.master             bus,
  output logic                     busy,
  output logic                     fin,
  output logic                     err
);

  state_t                   state_q;
  logic [TAB_N*SYM_W-1:0]   tab_q;
  logic [MAX_LEN*NIB_W-1:0] cnt_q;
  logic [CNT_W-1:0]         total_q;
  logic [CNT_W-1:0]         sym_cnt_q;
  logic [SYM_W-1:0]         sym_q;
  logic [MAX_LEN-1:0]       code_q;
  logic [IDX_W-1:0]         bit_idx_q;
  logic                     code_bit_q;
  logic                     bit_valid_q;

  logic [N_W-1:0]           n_codes_c;
  logic                     last_sym_c;
  logic                     lk_found_c;
  code_len_t                lk_cl_c;
  logic [IDX_W-1:0]         first_idx_c;

  assign n_codes_c   = count_sum(cnt_q);
  assign last_sym_c  = (sym_cnt_q + CNT_W'(1)) == total_q;
  assign first_idx_c = IDX_W'(lk_cl_c.len - LEN_W'(1));

  sq_code_lookup u_lookup (
    .symbol    (sym_q),
    .sym_table (tab_q),
    .counts    (cnt_q),
    .n_codes   (n_codes_c),
    .found     (lk_found_c),
    .cl        (lk_cl_c)
  );

  // Pop decode: the head is consumed on the edge that captures it, never when empty
  assign bus.rinc = ((state_q == FETCH) || ((state_q == NEXT) && !last_sym_c)) && !bus.rempty;

  assign bus.code_bit  = code_bit_q;
  assign bus.bit_valid = bit_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tab_q       <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      sym_cnt_q   <= '0;
      sym_q       <= '0;
      code_q      <= '0;
      bit_idx_q   <= '0;
      code_bit_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      busy        <= 1'b0;
      fin         <= 1'b0;
      err         <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tab_q     <= CCL_code_sq;
            cnt_q     <= CCL_count_sq;
            total_q   <= sym_total;
            sym_cnt_q <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state_q   <= CFG;
          end
        end
        CFG: begin
          if (n_codes_c > N_W'(TAB_N)) begin
            err     <= 1'b1;
            fin     <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
          end else if (total_q == '0) begin
            fin     <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.rempty) begin
            sym_q   <= bus.rdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_found_c) begin
            code_q      <= lk_cl_c.code;
            bit_idx_q   <= first_idx_c;
            code_bit_q  <= lk_cl_c.code[first_idx_c];
            bit_valid_q <= 1'b1;
            state_q     <= SHIFT;
          end else begin
            err     <= 1'b1;
            state_q <= NEXT;
          end
        end
        SHIFT: begin
          // bit_valid is high throughout, so ready alone marks a transfer
          if (bus.bit_ready) begin
            if (bit_idx_q == '0) begin
              bit_valid_q <= 1'b0;
              code_bit_q  <= 1'b0;
              state_q     <= NEXT;
            end else begin
              bit_idx_q  <= bit_idx_q - IDX_W'(1);
              code_bit_q <= code_q[bit_idx_q - IDX_W'(1)];
            end
          end
        end
        NEXT: begin
          sym_cnt_q <= sym_cnt_q + CNT_W'(1);
          if (last_sym_c) begin
            fin     <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
          end else if (!bus.rempty) begin
            sym_q   <= bus.rdata;
            state_q <= LOOKUP;
          end else begin
            state_q <= FETCH;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sq_encoder.sv
// Directed bench for sq_encoder with a FIFO model and an expected-bit scoreboard.
module tb_sq_encoder;
  import sq_pkg::*;

  localparam logic [63:0] CODE_A  = 64'h0000_0000_f942_10f5;
  localparam logic [15:0] CNT_A   = 16'h2510;
  localparam logic [15:0] CNT_BAD = 16'hF002;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] sym_total;
  logic [63:0] CCL_code_sq;
  logic [15:0] CCL_count_sq;
  logic        busy;
  logic        fin;
  logic        err;

  sq_encoder_if bus();

  sq_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sym_total    (sym_total),
    .CCL_code_sq  (CCL_code_sq),
    .CCL_count_sq (CCL_count_sq),
    .bus          (bus),
    .busy         (busy),
    .fin          (fin),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] fifo[$];
  logic [3:0] feed_q[$];
  logic       exp_bits[$];
  int         rinc_cyc[$];

  int   cyc = 0;
  int   fin_cnt, fin_cyc, rinc_cnt, valid_cnt, xfer_cnt, first_valid, start_cyc;
  int   feed_gap, feed_timer, rdy_ph;
  bit   ready_toggle;
  logic s_rinc, s_bit, s_valid, s_busy, s_fin, s_err;
  logic hold_pend = 1'b0;
  logic hold_bit  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: hand-derived codes for table {5,f,0,1,2,4,9,f}, counts {0,1,5,2}
  task automatic push_sym(input logic [3:0] s);
    logic [3:0] code;
    int         len;
    feed_q.push_back(s);
    case (s)
      4'h5:    begin code = 4'b0000; len = 2; end
      4'h0:    begin code = 4'b0011; len = 3; end
      4'h9:    begin code = 4'b1110; len = 4; end
      4'hf:    begin code = 4'b0010; len = 3; end
      4'h4:    begin code = 4'b0110; len = 3; end
      default: begin code = 4'b0000; len = 0; end
    endcase
    for (int i = len - 1; i >= 0; i--) exp_bits.push_back(code[i]);
  endtask

  // One clock: sample/check at negedge, then apply FIFO pop, feed and ready after the edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_rinc  = bus.rinc;
    s_bit   = bus.code_bit;
    s_valid = bus.bit_valid;
    s_busy  = busy;
    s_fin   = fin;
    s_err   = err;
    if (s_fin) begin fin_cnt++; fin_cyc = cyc; end
    if (s_valid) valid_cnt++;
    if (s_valid && first_valid < 0) first_valid = cyc;
    if (s_rinc) begin
      rinc_cnt++;
      rinc_cyc.push_back(cyc);
      check("rinc_while_empty", bus.rempty, 1'b0);
    end
    if (hold_pend) begin
      check("hold_valid", s_valid, 1'b1);
      check("hold_bit", s_bit, hold_bit);
    end
    hold_pend = s_valid && !bus.bit_ready && !rst;
    hold_bit  = s_bit;
    if (s_valid && bus.bit_ready) begin
      xfer_cnt++;
      check("bit_expected", exp_bits.size() != 0, 1'b1);
      if (exp_bits.size() != 0) check("bit", s_bit, exp_bits.pop_front());
    end
    @(posedge clk);
    #1;
    if (s_rinc && fifo.size() != 0) void'(fifo.pop_front());
    if (feed_gap == 0) begin
      while (feed_q.size() != 0) fifo.push_back(feed_q.pop_front());
    end else if (feed_timer > 0) begin
      feed_timer--;
    end else if (fifo.size() == 0 && feed_q.size() != 0) begin
      fifo.push_back(feed_q.pop_front());
      feed_timer = feed_gap;
    end
    if (ready_toggle) begin
      rdy_ph        = (rdy_ph + 1) % 4;
      bus.bit_ready = (rdy_ph < 2);
    end
    bus.rempty = (fifo.size() == 0);
    bus.rdata  = (fifo.size() != 0) ? fifo[0] : 4'h0;
  endtask

  task automatic new_job(input logic [63:0] code, input logic [15:0] counts,
                         input logic [15:0] total, input int gap, input bit toggle);
    fin_cnt      = 0;
    rinc_cnt     = 0;
    valid_cnt    = 0;
    xfer_cnt     = 0;
    first_valid  = -1;
    rinc_cyc.delete();
    feed_gap     = gap;
    feed_timer   = 0;
    ready_toggle = toggle;
    rdy_ph       = 0;
    bus.bit_ready = 1'b1;
    CCL_code_sq  = code;
    CCL_count_sq = counts;
    sym_total    = total;
    start        = 1'b1;
    tick();
    start_cyc    = cyc;
    start        = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    int n = 0;
    while (fin_cnt == 0 && n < 300) begin tick(); n++; end
    check({tag, "_fin_seen"}, fin_cnt != 0, 1'b1);
    repeat (3) tick();
    check({tag, "_fin_once"}, fin_cnt, 1);
  endtask

  task automatic end_checks(input string tag, input logic exp_err, input int exp_rinc);
    check({tag, "_err"}, s_err, exp_err);
    check({tag, "_bits_left"}, exp_bits.size(), 0);
    check({tag, "_rinc_cnt"}, rinc_cnt, exp_rinc);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    sym_total     = '0;
    CCL_code_sq   = '0;
    CCL_count_sq  = '0;
    bus.rdata     = '0;
    bus.rempty    = 1'b1;
    bus.bit_ready = 1'b0;
    feed_gap      = 0;
    feed_timer    = 0;
    ready_toggle  = 1'b0;
    rdy_ph        = 0;
    fin_cnt       = 0;
    rinc_cnt      = 0;
    valid_cnt     = 0;
    xfer_cnt      = 0;
    first_valid   = -1;
    repeat (3) tick();
    check("rst_rinc", s_rinc, 1'b0);
    check("rst_bit", s_bit, 1'b0);
    check("rst_valid", s_valid, 1'b0);
    check("rst_busy", s_busy, 1'b0);
    check("rst_fin", s_fin, 1'b0);
    check("rst_err", s_err, 1'b0);
    rst = 1'b0;
    tick();

    // Basic stream 00 011 1110, plus latency and throughput
    push_sym(4'h5); push_sym(4'h0); push_sym(4'h9);
    new_job(CODE_A, CNT_A, 16'd3, 0, 1'b0);
    tick();
    check("s1_busy", s_busy, 1'b1);
    wait_fin("s1");
    end_checks("s1", 1'b0, 3);
    check("s1_latency", first_valid - rinc_cyc[0], 2);
    check("s1_tput_len2", rinc_cyc[1] - rinc_cyc[0], 4);
    check("s1_tput_len3", rinc_cyc[2] - rinc_cyc[1], 5);
    check("s1_bits", xfer_cnt, 9);

    // Duplicate f: lowest index gives 010
    push_sym(4'hf);
    new_job(CODE_A, CNT_A, 16'd1, 0, 1'b0);
    wait_fin("s2");
    end_checks("s2", 1'b0, 1);
    check("s2_bits", xfer_cnt, 3);

    // Unknown symbol 3 then 4
    push_sym(4'h3); push_sym(4'h4);
    new_job(CODE_A, CNT_A, 16'd2, 0, 1'b0);
    wait_fin("s3");
    end_checks("s3", 1'b1, 2);
    check("s3_bits", xfer_cnt, 3);

    // Stalling sink and sparse FIFO; mid-job input changes and start are ignored
    push_sym(4'h5); push_sym(4'h0); push_sym(4'h9);
    new_job(CODE_A, CNT_A, 16'd3, 3, 1'b1);
    CCL_code_sq  = '1;
    CCL_count_sq = 16'hFFFF;
    sym_total    = 16'd1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    wait_fin("s4");
    end_checks("s4", 1'b0, 3);
    check("s4_bits", xfer_cnt, 9);

    // Zero symbols
    new_job(CODE_A, CNT_A, 16'd0, 0, 1'b0);
    wait_fin("s5a");
    end_checks("s5a", 1'b0, 0);
    check("s5a_fin_lat", fin_cyc - start_cyc, 2);
    check("s5a_valid", valid_cnt, 0);

    // Counts sum to 17
    new_job(CODE_A, CNT_BAD, 16'd3, 0, 1'b0);
    wait_fin("s5b");
    end_checks("s5b", 1'b1, 0);
    check("s5b_valid", valid_cnt, 0);

    // Reset in the middle of 1110
    push_sym(4'h5); push_sym(4'h0); push_sym(4'h9);
    new_job(CODE_A, CNT_A, 16'd3, 0, 1'b0);
    begin
      int n = 0;
      while (xfer_cnt < 6 && n < 100) begin tick(); n++; end
    end
    check("s6_reached", xfer_cnt, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("s6_rinc", s_rinc, 1'b0);
    check("s6_bit", s_bit, 1'b0);
    check("s6_valid", s_valid, 1'b0);
    check("s6_busy", s_busy, 1'b0);
    check("s6_fin", s_fin, 1'b0);
    check("s6_err", s_err, 1'b0);
    exp_bits.delete();
    repeat (4) tick();
    check("s6_no_fin", fin_cnt, 0);

    push_sym(4'h9);
    new_job(CODE_A, CNT_A, 16'd1, 0, 1'b0);
    wait_fin("s7");
    end_checks("s7", 1'b0, 1);
    check("s7_bits", xfer_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
